// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle main controller: state encodings,
// opcode constants, ALU function classes and the control-word payload.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 6;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_RTYPE_1 = 4'd3,
    S_RTYPE_2 = 4'd4,
    S_BRANCH  = 4'd5,
    S_JUMP    = 4'd6,
    S_MEMADD  = 4'd7,
    S_LW_1    = 4'd8,
    S_LW_2    = 4'd9,
    S_SW      = 4'd10,
    S_EXCEPT  = 4'd11
  } state_e;

  localparam logic [OPC_W-1:0] OP_RTYPE  = 6'b000000;
  localparam logic [OPC_W-1:0] OP_BRANCH = 6'b000001;
  localparam logic [OPC_W-1:0] OP_JUMP   = 6'b000010;
  localparam logic [OPC_W-1:0] OP_LW     = 6'b000011;
  localparam logic [OPC_W-1:0] OP_SW     = 6'b000101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Instruction/memory handshake and datapath control bundle of the main controller.
interface mc_main_ctrl_if
  import mc_pkg::*;
#(
  parameter int unsigned OP_W = 6
);
  logic               start;
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic [STATE_W-1:0] state;
  logic               exc_illegal;

  modport master (
    output start, op, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, exc_illegal
  );

  modport slave (
    input  start, op, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, exc_illegal
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore control decode of the controller state; only the FETCH PC/IR strobes
// follow mem_ready so the PC and IR update on the cycle memory delivers.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADD: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
      end
      S_LW_1: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_LW_2: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_SW: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPE_1: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_2: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle CPU main controller: state register, next-state logic and sticky
// illegal-opcode flag. Optional trap on unknown opcodes: ILLEGAL_OP_TRAP_EN.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned OP_W = 6
)(
  input logic           clk,
  input logic           rst_n,
  mc_main_ctrl_if.slave bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_FETCH;
      S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.op == OP_W'(OP_RTYPE))                                  state_d = S_RTYPE_1;
        else if (bus.op == OP_W'(OP_BRANCH))                            state_d = S_BRANCH;
        else if (bus.op == OP_W'(OP_JUMP))                              state_d = S_JUMP;
        else if (bus.op == OP_W'(OP_LW) || bus.op == OP_W'(OP_SW))      state_d = S_MEMADD;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d = S_EXCEPT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_MEMADD:  state_d = (bus.op == OP_W'(OP_LW)) ? S_LW_1 : S_SW;
      S_RTYPE_1: state_d = S_RTYPE_2;
      S_LW_1:    if (bus.mem_ready) state_d = S_LW_2;
      S_SW:      if (bus.mem_ready) state_d = S_FETCH;
      S_LW_2, S_RTYPE_2, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_EXCEPT:  state_d = S_EXCEPT;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic exc_q;

  // Sticky until reset; set on the DECODE->EXCEPT edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           exc_q <= 1'b0;
    else if (state_q == S_DECODE && state_d == S_EXCEPT)  exc_q <= 1'b1;
  end

  assign bus.exc_illegal = exc_q;
`else
  assign bus.exc_illegal = 1'b0;
`endif

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.state         = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: each task walks one instruction class or
// corner case and checks state and the packed control word every cycle.
module tb_mc_main_ctrl;

  // Control word order: pc_write, pc_write_cond, iord, mem_read, mem_write,
  // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
  localparam logic [15:0] C_ZERO       = 16'h0000;
  localparam logic [15:0] C_FETCH_RDY  = 16'h9410;
  localparam logic [15:0] C_FETCH_WAIT = 16'h1010;
  localparam logic [15:0] C_DECODE     = 16'h0030;
  localparam logic [15:0] C_RTYPE_1    = 16'h0048;
  localparam logic [15:0] C_RTYPE_2    = 16'h0280;
  localparam logic [15:0] C_BRANCH     = 16'h4045;
  localparam logic [15:0] C_JUMP       = 16'h8002;
  localparam logic [15:0] C_MEMADD     = 16'h0060;
  localparam logic [15:0] C_LW_1       = 16'h3000;
  localparam logic [15:0] C_LW_2       = 16'h0180;
  localparam logic [15:0] C_SW         = 16'h2800;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mc_main_ctrl_if #(.OP_W(6)) bus ();

  mc_main_ctrl #(.OP_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ctl();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || ctl() !== C_ZERO || bus.exc_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_async state=%0d ctl=%h exc=%b expected state=0 ctl=%h exc=0",
               bus.state, ctl(), bus.exc_illegal, C_ZERO);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd0 || ctl() !== C_ZERO) begin
      failures++;
      $display("FAIL idle_hold state=%0d ctl=%h expected state=0 ctl=%h",
               bus.state, ctl(), C_ZERO);
    end
  endtask

  // start stays high throughout to show it is ignored outside IDLE.
  task automatic test_rtype();
    logic [3:0]  es [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    logic [15:0] ec [5] = '{C_FETCH_RDY, C_DECODE, C_RTYPE_1, C_RTYPE_2, C_FETCH_RDY};
    bus.start = 1'b1;
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        failures++;
        $display("FAIL rtype[%0d] state=%0d ctl=%h expected state=%0d ctl=%h",
                 i, bus.state, ctl(), es[i], ec[i]);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_branch_jump();
    logic [3:0]  es [3];
    logic [15:0] ec [3];
    for (int k = 0; k < 2; k++) begin
      bus.op = (k == 0) ? 6'b000001 : 6'b000010;
      es = '{4'd2, (k == 0) ? 4'd5 : 4'd6, 4'd1};
      ec = '{C_DECODE, (k == 0) ? C_BRANCH : C_JUMP, C_FETCH_RDY};
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        checks++;
        if (bus.state !== es[i] || ctl() !== ec[i]) begin
          failures++;
          $display("FAIL %s[%0d] state=%0d ctl=%h expected state=%0d ctl=%h",
                   (k == 0) ? "branch" : "jump", i, bus.state, ctl(), es[i], ec[i]);
        end
      end
    end
  endtask

  task automatic test_store();
    logic [3:0]  es [4] = '{4'd2, 4'd7, 4'd10, 4'd1};
    logic [15:0] ec [4] = '{C_DECODE, C_MEMADD, C_SW, C_FETCH_RDY};
    bus.op = 6'b000101;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        failures++;
        $display("FAIL store[%0d] state=%0d ctl=%h expected state=%0d ctl=%h",
                 i, bus.state, ctl(), es[i], ec[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [3:0]  es [6] = '{4'd2, 4'd7, 4'd8, 4'd8, 4'd9, 4'd1};
    logic [15:0] ec [6] = '{C_DECODE, C_MEMADD, C_LW_1, C_LW_1, C_LW_2, C_FETCH_RDY};
    bus.op = 6'b000011;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.mem_ready = 1'b0;
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state !== es[i] || ctl() !== ec[i]) begin
        failures++;
        $display("FAIL load_wait[%0d] state=%0d ctl=%h expected state=%0d ctl=%h",
                 i, bus.state, ctl(), es[i], ec[i]);
      end
    end
  endtask

  // Enter from FETCH; hold mem_ready low for four FETCH cycles.
  task automatic test_fetch_wait();
    bus.op = 6'b000010;
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      checks++;
      if (bus.state !== 4'd1 || ctl() !== C_FETCH_WAIT) begin
        failures++;
        $display("FAIL fetch_wait[%0d] state=%0d ctl=%h expected state=1 ctl=%h",
                 i, bus.state, ctl(), C_FETCH_WAIT);
      end
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd1 || ctl() !== C_FETCH_RDY) begin
      failures++;
      $display("FAIL fetch_ready state=%0d ctl=%h expected state=1 ctl=%h",
               bus.state, ctl(), C_FETCH_RDY);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd2 || ctl() !== C_DECODE) begin
      failures++;
      $display("FAIL fetch_to_decode state=%0d ctl=%h expected state=2 ctl=%h",
               bus.state, ctl(), C_DECODE);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [3:0]  exp_s;
    logic [15:0] exp_c;
    logic        exp_e;
`ifdef ILLEGAL_OP_TRAP_EN
    exp_s = 4'd11; exp_c = C_ZERO;      exp_e = 1'b1;
`else
    exp_s = 4'd1;  exp_c = C_FETCH_RDY; exp_e = 1'b0;
`endif
    bus.op = 6'b111111;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd2) begin
      failures++;
      $display("FAIL illegal_decode state=%0d expected 2", bus.state);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.state !== exp_s || ctl() !== exp_c || bus.exc_illegal !== exp_e) begin
      failures++;
      $display("FAIL illegal_next state=%0d ctl=%h exc=%b expected state=%0d ctl=%h exc=%b",
               bus.state, ctl(), bus.exc_illegal, exp_s, exp_c, exp_e);
    end
`ifdef ILLEGAL_OP_TRAP_EN
    bus.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd11 || ctl() !== C_ZERO || bus.exc_illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_hold state=%0d ctl=%h exc=%b expected state=11 ctl=%h exc=1",
               bus.state, ctl(), bus.exc_illegal, C_ZERO);
    end
    bus.start = 1'b0;
`endif
  endtask

  task automatic test_reset_in_sw();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.exc_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_clears_exc state=%0d exc=%b expected state=0 exc=0",
               bus.state, bus.exc_illegal);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.op = 6'b000101;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd10 || ctl() !== C_SW) begin
      failures++;
      $display("FAIL sw_wait state=%0d ctl=%h expected state=10 ctl=%h",
               bus.state, ctl(), C_SW);
    end
    // Assert reset mid-cycle, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.mem_write !== 1'b0 || ctl() !== C_ZERO) begin
      failures++;
      $display("FAIL reset_in_sw state=%0d mem_write=%b ctl=%h expected state=0 mem_write=0 ctl=%h",
               bus.state, bus.mem_write, ctl(), C_ZERO);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd1 || ctl() !== C_FETCH_RDY) begin
      failures++;
      $display("FAIL restart state=%0d ctl=%h expected state=1 ctl=%h",
               bus.state, ctl(), C_FETCH_RDY);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch_jump();
    test_store();
    test_load_wait();
    test_fetch_wait();
    test_illegal();
    test_reset_in_sw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
MC_MAIN_CTRL -- requirements
Module: mc_main_ctrl

Interface
REQ-001 Parameter: OP_W, 6, opcode field width.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  leave IDLE and begin fetching.
REQ-005 op  input  OP_W  opcode from instruction register; stable from DECODE until the next FETCH.
REQ-006 mem_ready  input  1  memory completes current access this cycle.
REQ-007 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write  output  1 each  PC/memory/IR controls.
REQ-008 reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  register-file/ALU-A controls.
REQ-009 alu_src_b, alu_op, pc_source  output  2 each  ALU-B mux, ALU function class, PC mux.
REQ-010 state  output  4  current state encoding (debug).
REQ-011 exc_illegal  output  1  illegal-opcode flag (macro-dependent).

Function
REQ-012 Encodings SHALL be: IDLE 0, FETCH 1, DECODE 2, RTYPE_1 3, RTYPE_2 4, BRANCH 5, JUMP 6, MEMADD 7, LW_1 8, LW_2 9, SW 10, EXCEPT 11; 12-15 unreachable, recover to IDLE next edge.
REQ-013 Opcodes SHALL be: RTYPE 000000, BRANCH 000001, JUMP 000010, LW 000011, SW 000101.
REQ-014 Transitions: IDLE->FETCH when start=1, else hold; FETCH->DECODE when mem_ready=1, else hold.
REQ-015 DECODE SHALL go to RTYPE_1/BRANCH/JUMP per op, MEMADD for LW or SW; other ops per REQ-027/028.
REQ-016 MEMADD->LW_1 when op=LW, else SW; RTYPE_1->RTYPE_2 unconditionally.
REQ-017 LW_1->LW_2 and SW->FETCH only when mem_ready=1, else hold; LW_2, RTYPE_2, BRANCH, JUMP ->FETCH unconditionally.
REQ-018 start is ignored outside IDLE; state register is the only sequential element besides exc_illegal.
REQ-019 Outputs are Moore decodes of the state register, except pc_write and ir_write in FETCH, which equal mem_ready.
REQ-020 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; MEMADD: alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-022 LW_1: iord=1, mem_read=1; LW_2: reg_write=1, mem_to_reg=1, reg_dst=0; SW: iord=1, mem_write=1.
REQ-023 RTYPE_1: alu_src_a=1, alu_src_b=00, alu_op=10; RTYPE_2: reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; JUMP: pc_write=1, pc_source=10.
REQ-025 Every control not listed for a state SHALL be 0; mem_read and mem_write never both 1.
REQ-026 Instruction latency without waits: R-type 4, branch 3, jump 3, load 5, store 4 cycles (FETCH to FETCH).

Configuration
REQ-027 With ILLEGAL_OP_TRAP_EN defined: unknown op in DECODE SHALL go to EXCEPT, set exc_illegal=1; EXCEPT holds with all controls 0 until rst_n.
REQ-028 Without ILLEGAL_OP_TRAP_EN: unknown op SHALL go DECODE->FETCH (NOP); EXCEPT unreachable; exc_illegal tied 0.

Reset
REQ-029 rst_n=0 SHALL force state=IDLE and exc_illegal=0 immediately, regardless of clk, including mid-access (FETCH/LW_1/SW wait).
REQ-030 During and after reset, all control outputs SHALL be 0 until FETCH is entered; deassertion is assumed synchronised externally.

Structure
REQ-031 Shared package mc_pkg SHALL hold state encodings, opcode constants and alu_op codes (00 add, 01 sub, 10 funct).
REQ-032 Control decode SHALL be one sub-module, mc_ctrl_decode (state, mem_ready -> controls); next-state and register stay in mc_main_ctrl.

Verification
REQ-033 Reset, start=1, op=000000, mem_ready=1 -> states 1,2,3,4,1; reg_write=1, reg_dst=1 only in state 4.
REQ-034 op=000011, mem_ready low 2 cycles in LW_1 -> LW_1 held 3 cycles, mem_read=iord=1 throughout, then LW_2 with mem_to_reg=1.
REQ-035 op=000101 -> 1,2,7,10,1; mem_write=1 only in state 10; op=000001 -> pc_write_cond=1, pc_source=01 in state 5.
REQ-036 FETCH with mem_ready=0 for 4 cycles -> pc_write=ir_write=0 during wait, both 1 on the ready cycle, then DECODE.
REQ-037 op=111111 in DECODE -> with macro: state 11, exc_illegal=1 held; without: state 1 next, exc_illegal=0.
REQ-038 rst_n pulsed low in SW wait -> state=0 and mem_write=0 asynchronously; start=1 restarts at FETCH.
